trace_recorder: RTL
===================

Name: trace_recorder

Overview:
- Commit-trace capture stage directly downstream of the single-cycle CPU (sccomp_dataflow).
- Each cycle the CPU retires an instruction, the block buffers {pc, inst} in a FIFO and streams it out over a valid/ready port to the board-level dumper or comparator.
- Detects program end as two consecutively committed all-zero instructions, drains the FIFO, then flags halted.

Parameters:
- FIFO_DEPTH, 16, number of trace records buffered; power of 2, at least 2.
- ADDR_W, 4, log2(FIFO_DEPTH).
- DROP_W, 16, width of the saturating dropped-record counter.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high; clears all state.
- commit_valid  in  1  CPU retired an instruction this cycle.
- commit_pc  in  32  pc of the retired instruction.
- commit_inst  in  32  retired instruction word.
- trace_data  out  64  {pc[63:32], inst[31:0]} of the head record.
- trace_valid  out  1  head record available.
- trace_ready  in  1  consumer accepts the head record.
- cpu_stall  out  1  hold the CPU; constant 0 unless TRACE_STALL_EN.
- level  out  ADDR_W+1  current FIFO occupancy, 0..FIFO_DEPTH.
- overflow  out  1  sticky: at least one record dropped.
- drop_cnt  out  DROP_W  dropped records, saturating at all-ones.
- halted  out  1  program end detected and FIFO fully drained.

Behaviour:
- Reset values (reset=1 at a rising edge):
  - state=RUN, FIFO empty, level=0, trace_valid=0, overflow=0, drop_cnt=0, halted=0, nop_seen=0, cpu_stall=0.
  - trace_data is don't-care while trace_valid=0.
  - Reset mid-stream discards all buffered records with no partial output.
- FIFO:
  - First-word fall-through. trace_valid = (level != 0). trace_data = mem[rd_ptr].
  - A commit at edge N is visible on trace_valid/trace_data after edge N (1-cycle latency).
- Pop: trace_valid & trace_ready at an edge advances rd_ptr. trace_data must hold stable while trace_valid=1 and trace_ready=0.
- Push condition: commit_valid & state==RUN & !halt_hit & (level<FIFO_DEPTH | pop).
  - Simultaneous push and pop at full is allowed; level is unchanged.
  - Push and pop at level=1 leaves level=1 and the new record at the head next cycle.
  - Pointers wrap modulo FIFO_DEPTH.
- Drop: commit_valid & state==RUN & !halt_hit & full & !pop.
  - The record is discarded, overflow is set, and drop_cnt increments, saturating with no wrap.
- Halt detection in RUN:
  - nop_seen updates on every commit_valid to (commit_inst==32'h0).
  - halt_hit = commit_valid & commit_inst==32'h0 & nop_seen.
  - The first nop is recorded. The second nop is not recorded and not counted as a drop. State goes to DRAIN.
- States:
  - RUN: accept commits. On halt_hit, go to DRAIN.
  - DRAIN: commits are ignored, with no drop and no count. When level==0 (including level reaching 0 via a pop this edge, evaluated next cycle), go to DONE.
  - DONE: halted=1, commits ignored, trace_valid=0. Leaves only on reset.
- Non-consecutive nops: a nop followed by a nonzero instruction clears nop_seen. Cycles with commit_valid=0 do not clear nop_seen.

Optional Feature:
- Macro TRACE_STALL_EN.
- Defined:
  - cpu_stall = full & !(trace_valid & trace_ready), combinational, in RUN only; 0 in DRAIN and DONE.
  - The CPU holds the commit while stalled, so no record is lost under back-pressure.
  - A commit_valid presented while cpu_stall=1 is still dropped and counted, so bench protocol violations stay visible.
- Undefined: cpu_stall tied to 0; drop-on-full as above.

Decomposition:
- Package trace_pkg:
  - REC_W=64.
  - NOP_INST=32'h00000000.
  - State encoding: RUN=2'd0, DRAIN=2'd1, DONE=2'd2.
  - Helper for packing {pc, inst}.
- Sub-module trace_fifo (parameters FIFO_DEPTH, ADDR_W, REC_W):
  - Ports: push, pop, wdata, rdata, level, full, empty.
  - Holds pointers, level counter, memory.
- trace_recorder holds the FSM, halt detection, drop accounting and the stall logic.

Test Plan:
- Basic stream: commits pc 0x00400000/0x00400004/0x00400008 with insts 0x20010001/0x20020002/0x00221820, trace_ready=1 -> three records in order, each 1 cycle after its commit; level returns to 0.
- Back-pressure: trace_ready=0, 16 commits -> level=16, trace_valid=1, head=first record; trace_data stable throughout.
- Overflow: continue with 3 more commits -> drop_cnt=3, overflow=1. Then trace_ready=1 -> exactly the first 16 records emerge.
- Push+pop at full: level=16, commit with trace_ready=1 -> level stays 16, record accepted, drop_cnt unchanged.
- Halt: commits 0x00000000, 0x00000000 with 2 records already queued, trace_ready toggling -> first nop output, second not output. halted=1 only after the final pop; later commits ignored. Also: nop, 0x20010001, nop -> no halt.
- TRACE_STALL_EN: fill to 16 with trace_ready=0 -> cpu_stall=1. Assert trace_ready -> cpu_stall=0 in the same cycle; no drops. Finally, reset mid-DRAIN -> level=0, halted=0, state RUN.

Source files
------------

// File: rtl/trace_pkg.sv
// -----------------------------------------------------------------------------
// trace_pkg
//   Shared definitions for the commit-trace recorder: record width, the
//   instruction word that marks program end, the recorder state encoding and
//   a helper that packs a {pc, inst} trace record.
// -----------------------------------------------------------------------------
package trace_pkg;

   localparam int REC_W = 64;
   localparam logic [31:0] NOP_INST = 32'h0000_0000;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_DRAIN = 2'd1,
      ST_DONE  = 2'd2
   } state_e;

   // pc occupies the upper half so a hex dump reads "pc_inst".
   function automatic logic [REC_W-1:0] pack_rec(input logic [31:0] pc,
                                                input logic [31:0] inst);
      return {pc, inst};
   endfunction

endpackage

// File: rtl/trace_fifo.sv
// -----------------------------------------------------------------------------
// trace_fifo
//   First-word fall-through FIFO for trace records. rdata always shows the
//   head entry; a push is visible on rdata/level one cycle after its edge.
//   The caller guarantees pop only when non-empty and push at full only
//   together with pop.
//
// Ports
//   clk    in   clock, rising edge
//   reset  in   synchronous active-high, empties the FIFO
//   push   in   write wdata at the tail this edge
//   pop    in   retire the head entry this edge
//   wdata  in   REC_W record to write
//   rdata  out  REC_W head record (don't-care when empty)
//   level  out  ADDR_W+1 occupancy, 0..FIFO_DEPTH
//   full   out  level == FIFO_DEPTH
//   empty  out  level == 0
// -----------------------------------------------------------------------------
module trace_fifo #(
   parameter int FIFO_DEPTH = 16,
   parameter int ADDR_W     = 4,
   parameter int REC_W      = 64
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              push,
   input  logic              pop,
   input  logic [REC_W-1:0]  wdata,
   output logic [REC_W-1:0]  rdata,
   output logic [ADDR_W:0]   level,
   output logic              full,
   output logic              empty
);

   logic [REC_W-1:0] mem_q [FIFO_DEPTH];
   logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [ADDR_W:0]   level_q, level_d;

   // Depth is a power of two, so pointers wrap simply by overflowing.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (push) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + ADDR_W'(1);
      case ({push, pop})
         2'b10:   level_d = level_q + (ADDR_W+1)'(1);
         2'b01:   level_d = level_q - (ADDR_W+1)'(1);
         default: level_d = level_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

   // Storage carries no reset; validity is tracked by the pointers alone.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= wdata;
   end

   assign rdata = mem_q[rd_ptr_q];
   assign level = level_q;
   assign full  = (level_q == (ADDR_W+1)'(FIFO_DEPTH));
   assign empty = (level_q == '0);

endmodule

// File: rtl/trace_recorder.sv
// -----------------------------------------------------------------------------
// trace_recorder
//   Commit-trace capture stage behind the single-cycle CPU. Every retired
//   instruction is buffered as {pc, inst} and streamed out over a
//   valid/ready port. Two consecutively committed all-zero instructions mark
//   program end: the second one is swallowed, the FIFO drains, then halted
//   rises and stays until reset.
//
//   Optional build macro TRACE_STALL_EN: when defined, cpu_stall asks the CPU
//   to hold its commit while the FIFO is full and not popping (RUN only).
//   When undefined, cpu_stall is tied low and commits at full are dropped.
//
// Ports
//   clk           in   clock, rising edge
//   reset         in   synchronous active-high, clears all state
//   commit_valid  in   CPU retired an instruction this cycle
//   commit_pc     in   32-bit pc of the retired instruction
//   commit_inst   in   32-bit retired instruction word
//   trace_data    out  64-bit {pc, inst} head record
//   trace_valid   out  head record available
//   trace_ready   in   consumer accepts the head record
//   cpu_stall     out  hold the CPU (TRACE_STALL_EN only, else 0)
//   level         out  ADDR_W+1 FIFO occupancy
//   overflow      out  sticky, at least one record dropped
//   drop_cnt      out  DROP_W saturating dropped-record count
//   halted        out  program end seen and FIFO drained
// -----------------------------------------------------------------------------
module trace_recorder
   import trace_pkg::*;
#(
   parameter int FIFO_DEPTH = 16,
   parameter int ADDR_W     = 4,
   parameter int DROP_W     = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              commit_valid,
   input  logic [31:0]       commit_pc,
   input  logic [31:0]       commit_inst,
   output logic [REC_W-1:0]  trace_data,
   output logic              trace_valid,
   input  logic              trace_ready,
   output logic              cpu_stall,
   output logic [ADDR_W:0]   level,
   output logic              overflow,
   output logic [DROP_W-1:0] drop_cnt,
   output logic              halted
);

   state_e            state_q, state_d;
   logic              nop_seen_q, nop_seen_d;
   logic              overflow_q, overflow_d;
   logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;

   logic fifo_push, fifo_pop, fifo_full, fifo_empty;
   logic in_run, is_nop, halt_hit, take, drop;
   logic [REC_W-1:0] fifo_rdata;

   trace_fifo #(
      .FIFO_DEPTH (FIFO_DEPTH),
      .ADDR_W     (ADDR_W),
      .REC_W      (REC_W)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (fifo_push),
      .pop   (fifo_pop),
      .wdata (pack_rec(commit_pc, commit_inst)),
      .rdata (fifo_rdata),
      .level (level),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   always_comb begin
      in_run      = (state_q == ST_RUN);
      is_nop      = (commit_inst == NOP_INST);
      trace_valid = !fifo_empty && (state_q != ST_DONE);
      fifo_pop    = trace_valid && trace_ready;
      // The terminating nop is neither recorded nor counted as a drop.
      halt_hit    = in_run && commit_valid && is_nop && nop_seen_q;
      take        = in_run && commit_valid && !halt_hit;
      // At full a simultaneous pop frees the slot, so the push still lands.
      fifo_push   = take && (!fifo_full || fifo_pop);
      drop        = take && fifo_full && !fifo_pop;
   end

   always_comb begin
      state_d    = state_q;
      nop_seen_d = nop_seen_q;
      overflow_d = overflow_q;
      drop_cnt_d = drop_cnt_q;

      // Idle cycles keep nop_seen; only a nonzero commit breaks the pair.
      if (in_run && commit_valid) nop_seen_d = is_nop;

      if (drop) begin
         overflow_d = 1'b1;
         if (drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + DROP_W'(1);
      end

      case (state_q)
         ST_RUN:   if (halt_hit) state_d = ST_DRAIN;
         // Registered level: a final pop this edge is seen next cycle.
         ST_DRAIN: if (fifo_empty) state_d = ST_DONE;
         ST_DONE:  state_d = ST_DONE;
         default:  state_d = ST_RUN;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_RUN;
         nop_seen_q <= 1'b0;
         overflow_q <= 1'b0;
         drop_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         nop_seen_q <= nop_seen_d;
         overflow_q <= overflow_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end

`ifdef TRACE_STALL_EN
   // Combinational so a same-cycle trace_ready releases the CPU at once.
   assign cpu_stall = in_run && fifo_full && !fifo_pop;
`else
   assign cpu_stall = 1'b0;
`endif

   assign trace_data = fifo_rdata;
   assign overflow   = overflow_q;
   assign drop_cnt   = drop_cnt_q;
   assign halted     = (state_q == ST_DONE);

endmodule
